// File: rtl/wavelet_row_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// essentials : tile geometry, row type and sequencer enums
// Rev 1.0
// ============================================================================
package essentials;

   localparam int LENGTH = 8;
   localparam int NIT    = LENGTH / 2;
   localparam int IT_W   = $clog2(NIT) + 1;

   typedef logic [LENGTH-1:0][7:0] row_t;

   typedef enum logic [1:0] {
      FIRST  = 2'd0,
      MIDDLE = 2'd1,
      LAST   = 2'd2
   } iter_flag_e;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FETCH    = 3'd1,
      LAST_CAP = 3'd2,
      FIRE     = 3'd3,
      WAIT_HI  = 3'd4,
      WAIT_LO  = 3'd5,
      DONE     = 3'd6
   } seq_state_e;

   function automatic iter_flag_e flag_for(input logic [IT_W-1:0] k);
      if (k == IT_W'(NIT - 1)) return LAST;
      if (k == '0) return FIRST;
      return MIDDLE;
   endfunction

endpackage
`default_nettype wire

// File: rtl/wavelet_row_sequencer.sv
`default_nettype none
// ============================================================================
// wavelet_row_sequencer : fetches tile rows and steps block_processor through
// one pass with a start/done handshake and a result timeout
// Rev 1.0
// ============================================================================
module wavelet_row_sequencer
   import essentials::*;
#(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  row_t              mem_rdata,
   output logic              bp_en,
   output logic [1:0]        bp_iter_flag,
   output row_t              bp_row_0,
   output row_t              bp_row_1,
   output row_t              bp_row_2,
   input  logic              bp_result
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);

   generate
      if ((LENGTH % 2) != 0 || LENGTH < 4) begin : g_length_check
         $error("LENGTH must be even and >= 4");
      end
   endgenerate

   seq_state_e        state_q, state_d;
   iter_flag_e        flag_q, flag_d, flag_nx;
   logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic              mem_rd_q, mem_rd_d, bp_en_q, bp_en_d, cap_q, cap_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        dst_q, dst_d, cap_dst_q, cap_dst_d, left_q, left_d;
   logic [IT_W-1:0]   it_q, it_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   row_t              row0_q, row0_d, row1_q, row1_d, row2_q, row2_d;

   always_comb begin
      state_d   = state_q;
      flag_d    = flag_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = err_q;
      mem_rd_d  = 1'b0;
      bp_en_d   = 1'b0;
      addr_d    = addr_q;
      dst_d     = dst_q;
      left_d    = left_q;
      it_d      = it_q;
      tmo_d     = tmo_q;
      row0_d    = row0_q;
      row1_d    = row1_q;
      row2_d    = row2_q;
      flag_nx   = flag_for(it_q + IT_W'(1));
      // read data arrives one cycle after its strobe, so steering lags by one
      cap_d     = mem_rd_q;
      cap_dst_d = dst_q;

      if (cap_q) begin
         case (cap_dst_q)
            2'd0:    row0_d = mem_rdata;
            2'd1:    row1_d = mem_rdata;
            default: row2_d = mem_rdata;
         endcase
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = FETCH;
               busy_d   = 1'b1;
               err_d    = 1'b0;
               mem_rd_d = 1'b1;
               addr_d   = base_addr;
               dst_d    = 2'd0;
               left_d   = 2'd2;
               it_d     = '0;
               flag_d   = FIRST;
            end
         end
         FETCH: begin
            // every iteration's rows follow the previous read contiguously
            if (left_q != 2'd0) begin
               mem_rd_d = 1'b1;
               addr_d   = addr_q + ADDR_W'(1);
               dst_d    = dst_q + 2'd1;
               left_d   = left_q - 2'd1;
            end else begin
               state_d = LAST_CAP;
            end
         end
         LAST_CAP: begin
            state_d = FIRE;
            bp_en_d = 1'b1;
            tmo_d   = '0;
         end
         FIRE: begin
            state_d = WAIT_HI;
            tmo_d   = tmo_q + TMO_W'(1);
         end
         WAIT_HI: begin
            if (bp_result) begin
               state_d = WAIT_LO;
            end else if (tmo_q >= TMO_W'(TIMEOUT - 1)) begin
               state_d = DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         WAIT_LO: begin
            if (!bp_result) begin
               if (flag_q == LAST) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d  = FETCH;
                  mem_rd_d = 1'b1;
                  addr_d   = addr_q + ADDR_W'(1);
                  dst_d    = 2'd1;
                  left_d   = (flag_nx == LAST) ? 2'd0 : 2'd1;
                  it_d     = it_q + IT_W'(1);
                  flag_d   = flag_nx;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         flag_q    <= FIRST;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         mem_rd_q  <= 1'b0;
         bp_en_q   <= 1'b0;
         cap_q     <= 1'b0;
         addr_q    <= '0;
         dst_q     <= '0;
         cap_dst_q <= '0;
         left_q    <= '0;
         it_q      <= '0;
         tmo_q     <= '0;
         row0_q    <= '0;
         row1_q    <= '0;
         row2_q    <= '0;
      end else begin
         state_q   <= state_d;
         flag_q    <= flag_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         mem_rd_q  <= mem_rd_d;
         bp_en_q   <= bp_en_d;
         cap_q     <= cap_d;
         addr_q    <= addr_d;
         dst_q     <= dst_d;
         cap_dst_q <= cap_dst_d;
         left_q    <= left_d;
         it_q      <= it_d;
         tmo_q     <= tmo_d;
         row0_q    <= row0_d;
         row1_q    <= row1_d;
         row2_q    <= row2_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;
   assign mem_rd       = mem_rd_q;
   assign mem_addr     = addr_q;
   assign bp_en        = bp_en_q;
   assign bp_iter_flag = flag_q;
   assign bp_row_0     = row0_q;
   assign bp_row_1     = row1_q;
   assign bp_row_2     = row2_q;

endmodule
`default_nettype wire

// File: tb/tb_wavelet_row_sequencer.sv
`default_nettype none
// ============================================================================
// tb_wavelet_row_sequencer : randomized passes checked against a row-plan model
// Rev 1.0
// ============================================================================
module tb_wavelet_row_sequencer;
   import essentials::*;

   localparam int AW  = 8;
   localparam int TMO = 16;

   logic          clk;
   logic          resetn;
   logic          start;
   logic [AW-1:0] base_addr;
   logic          busy, done, err, mem_rd, bp_en;
   logic [AW-1:0] mem_addr;
   logic [1:0]    bp_iter_flag;
   row_t          mem_rdata, bp_row_0, bp_row_1, bp_row_2;
   logic          bp_result;

   wavelet_row_sequencer #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
      .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
      .busy(busy), .done(done), .err(err), .mem_rd(mem_rd), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .bp_en(bp_en), .bp_iter_flag(bp_iter_flag),
      .bp_row_0(bp_row_0), .bp_row_1(bp_row_1), .bp_row_2(bp_row_2),
      .bp_result(bp_result)
   );

   int         n_cmp, n_err, cyc;
   bit         rsp_enable;
   int         rsp_wait, rsp_hold;
   bit         rsp_active;
   int         rd_cyc_q[$], fire_cyc_q[$], done_cyc_q[$], fall_q[$];
   logic [7:0] rd_addr_q[$];
   logic [1:0] fire_flag_q[$];
   row_t       fire_r0_q[$], fire_r1_q[$], fire_r2_q[$];
   logic       done_err_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   function automatic row_t mk(input logic [7:0] v);
      row_t r;
      for (int i = 0; i < LENGTH; i++) r[i] = v;
      return r;
   endfunction

   // frame memory: row at address a holds a in every byte; garbage when not read
   initial begin
      bit         p;
      logic [7:0] a;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         p = mem_rd;
         a = mem_addr;
         @(posedge clk);
         #1;
         if (p) mem_rdata = mk(a);
         else for (int i = 0; i < LENGTH; i++) mem_rdata[i] = 8'($urandom);
      end
   end

   // block_processor stand-in: random latency, random high time
   initial begin
      bp_result = 1'b0;
      rsp_active = 1'b0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            bp_result = 1'b0;
            rsp_active = 1'b0;
         end else if (rsp_active) begin
            if (rsp_wait > 0) rsp_wait--;
            else if (!bp_result) bp_result = 1'b1;
            else if (rsp_hold > 1) rsp_hold--;
            else begin
               bp_result = 1'b0;
               rsp_active = 1'b0;
               fall_q.push_back(cyc);
            end
         end else if (bp_en && rsp_enable) begin
            rsp_wait = $urandom_range(0, 5);
            rsp_hold = $urandom_range(1, 3);
            rsp_active = 1'b1;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (mem_rd) begin
            rd_cyc_q.push_back(cyc);
            rd_addr_q.push_back(mem_addr);
         end
         if (bp_en) begin
            fire_cyc_q.push_back(cyc);
            fire_flag_q.push_back(bp_iter_flag);
            fire_r0_q.push_back(bp_row_0);
            fire_r1_q.push_back(bp_row_1);
            fire_r2_q.push_back(bp_row_2);
         end
         if (done) begin
            done_cyc_q.push_back(cyc);
            done_err_q.push_back(err);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_log();
      rd_cyc_q.delete(); rd_addr_q.delete(); fire_cyc_q.delete(); fire_flag_q.delete();
      fire_r0_q.delete(); fire_r1_q.delete(); fire_r2_q.delete();
      done_cyc_q.delete(); done_err_q.delete(); fall_q.delete();
   endtask

   task automatic run_pass(input logic [7:0] base, input bit poke, output int s);
      bit got;
      clear_log();
      @(negedge clk);
      start = 1'b1;
      base_addr = base;
      s = cyc;
      @(negedge clk);
      start = 1'b0;
      base_addr = 8'($urandom);
      n_cmp++;
      if (busy !== 1'b1 || err !== 1'b0) begin
         n_err++;
         $display("FAIL start_accept: busy=%b err=%b want busy=1 err=0", busy, err);
      end
      got = 1'b0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            break;
         end
         start = poke && ($urandom_range(0, 3) == 0);
         base_addr = 8'($urandom);
      end
      n_cmp++;
      if (!got) begin
         n_err++;
         $display("FAIL done_wait: no done within 400 cycles, want a done pulse");
      end
      start = poke;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic check_pass(input logic [7:0] base, input int s);
      int         e0, e1, e2, nrd, ef, exp_c;
      logic [7:0] ea;
      n_cmp++;
      if (rd_addr_q.size() != LENGTH) begin
         n_err++;
         $display("FAIL read_count: got %0d want %0d", rd_addr_q.size(), LENGTH);
      end
      for (int r = 0; r < rd_addr_q.size() && r < LENGTH; r++) begin
         ea = base + 8'(r);
         n_cmp++;
         if (rd_addr_q[r] !== ea) begin
            n_err++;
            $display("FAIL read_addr[%0d]: got %h want %h", r, rd_addr_q[r], ea);
         end
      end
      n_cmp++;
      if (rd_cyc_q.size() < 3 || rd_cyc_q[0] != s + 1 || rd_cyc_q[2] != s + 3) begin
         n_err++;
         $display("FAIL read_timing: first read cycle %0d want %0d",
                  rd_cyc_q.size() > 0 ? rd_cyc_q[0] : -1, s + 1);
      end
      n_cmp++;
      if (fire_cyc_q.size() != NIT) begin
         n_err++;
         $display("FAIL fire_count: got %0d want %0d", fire_cyc_q.size(), NIT);
      end
      e0 = 0; e1 = 0; e2 = 0;
      for (int k = 0; k < fire_cyc_q.size() && k < NIT; k++) begin
         if (k == 0) begin
            e0 = 0; e1 = 1; e2 = 2; ef = 0; nrd = 3;
         end else if (k == NIT - 1) begin
            e1 = LENGTH - 1; ef = 2; nrd = 1;
         end else begin
            e1 = 2 * k + 1; e2 = 2 * k + 2; ef = 1; nrd = 2;
         end
         n_cmp++;
         if (fire_flag_q[k] !== 2'(ef)) begin
            n_err++;
            $display("FAIL iter_flag[%0d]: got %0d want %0d", k, fire_flag_q[k], ef);
         end
         n_cmp++;
         if ({fire_r0_q[k], fire_r1_q[k], fire_r2_q[k]} !==
             {mk(base + 8'(e0)), mk(base + 8'(e1)), mk(base + 8'(e2))}) begin
            n_err++;
            $display("FAIL rows[%0d]: got %h/%h/%h want rows %0d/%0d/%0d of base %h",
                     k, fire_r0_q[k], fire_r1_q[k], fire_r2_q[k], e0, e1, e2, base);
         end
         if (k == 0) exp_c = s + 5;
         else if (k - 1 < fall_q.size()) exp_c = fall_q[k-1] + nrd + 2;
         else exp_c = -1;
         n_cmp++;
         if (fire_cyc_q[k] != exp_c) begin
            n_err++;
            $display("FAIL fire_timing[%0d]: got cycle %0d want %0d", k, fire_cyc_q[k], exp_c);
         end
      end
      n_cmp++;
      if (done_cyc_q.size() != 1 || fall_q.size() != NIT || done_cyc_q[0] != fall_q[NIT-1] + 1) begin
         n_err++;
         $display("FAIL done_timing: got %0d done pulses (first at %0d) want 1 at last fall + 1",
                  done_cyc_q.size(), done_cyc_q.size() > 0 ? done_cyc_q[0] : -1);
      end
      n_cmp++;
      if (done_err_q.size() != 1 || done_err_q[0] !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL pass_end: err=%b busy=%b want err=0 busy=0", err, busy);
      end
   endtask

   task automatic test_reset();
      n_cmp++;
      if ({busy, done, err, mem_rd, bp_en, bp_iter_flag} !== 7'd0 || mem_addr !== 8'd0) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b addr %h want all zero",
                  {busy, done, err, mem_rd, bp_en, bp_iter_flag}, mem_addr);
      end
      n_cmp++;
      if ({bp_row_0, bp_row_1, bp_row_2} !== '0) begin
         n_err++;
         $display("FAIL reset_rows: got %h/%h/%h want 0", bp_row_0, bp_row_1, bp_row_2);
      end
      @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({busy, done, mem_rd, bp_en} !== 4'd0) begin
         n_err++;
         $display("FAIL idle_after_reset: got %b want 0000", {busy, done, mem_rd, bp_en});
      end
   endtask

   task automatic test_basic();
      int s;
      run_pass(8'h10, 1'b0, s);
      check_pass(8'h10, s);
   endtask

   task automatic test_random();
      int         s;
      logic [7:0] b;
      for (int i = 0; i < 4; i++) begin
         b = (i == 0) ? 8'hFC : 8'($urandom);
         run_pass(b, 1'b0, s);
         check_pass(b, s);
      end
   endtask

   task automatic test_timeout();
      int         s;
      logic [7:0] b;
      rsp_enable = 1'b0;
      run_pass(8'hA0, 1'b0, s);
      n_cmp++;
      if (fire_cyc_q.size() != 1 || rd_addr_q.size() != 3) begin
         n_err++;
         $display("FAIL timeout_activity: got %0d fires %0d reads want 1 and 3",
                  fire_cyc_q.size(), rd_addr_q.size());
      end
      n_cmp++;
      if (done_cyc_q.size() != 1 || fire_cyc_q.size() < 1 || done_cyc_q[0] - fire_cyc_q[0] != TMO) begin
         n_err++;
         $display("FAIL timeout_delay: got %0d done pulses, delay %0d want 1 pulse delay %0d",
                  done_cyc_q.size(),
                  (done_cyc_q.size() > 0 && fire_cyc_q.size() > 0) ? done_cyc_q[0] - fire_cyc_q[0] : -1,
                  TMO);
      end
      n_cmp++;
      if (done_err_q.size() != 1 || done_err_q[0] !== 1'b1 || err !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL timeout_err: err=%b busy=%b want err=1 busy=0 (sticky)", err, busy);
      end
      rsp_enable = 1'b1;
      b = 8'($urandom);
      run_pass(b, 1'b0, s);
      check_pass(b, s);
   endtask

   task automatic test_ignored_start();
      int         s;
      logic [7:0] b;
      for (int i = 0; i < 2; i++) begin
         b = 8'($urandom);
         run_pass(b, 1'b1, s);
         check_pass(b, s);
      end
   endtask

   task automatic test_reset_mid();
      int         s;
      bit         got;
      logic [7:0] b;
      clear_log();
      rsp_enable = 1'b0;
      @(negedge clk);
      start = 1'b1;
      base_addr = 8'h55;
      @(negedge clk);
      start = 1'b0;
      got = 1'b0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (bp_en) begin
            got = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!got) begin
         n_err++;
         $display("FAIL mid_fire_wait: no bp_en within 60 cycles, want one");
      end
      repeat (3) @(negedge clk);
      #2;
      resetn = 1'b0;
      #1;
      n_cmp++;
      if ({busy, done, err, mem_rd, bp_en, bp_iter_flag, mem_addr} !== '0 ||
          {bp_row_0, bp_row_1, bp_row_2} !== '0) begin
         n_err++;
         $display("FAIL async_reset: ctrl %b addr %h rows %h/%h/%h want all zero",
                  {busy, done, err, mem_rd, bp_en, bp_iter_flag}, mem_addr,
                  bp_row_0, bp_row_1, bp_row_2);
      end
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (done_cyc_q.size() != 0) begin
         n_err++;
         $display("FAIL reset_no_done: got %0d done pulses want 0", done_cyc_q.size());
      end
      rsp_enable = 1'b1;
      b = 8'($urandom);
      run_pass(b, 1'b0, s);
      check_pass(b, s);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rsp_enable = 1'b1;
      resetn = 1'b0;
      start = 1'b0;
      base_addr = '0;
      repeat (3) @(negedge clk);
      test_reset();
      test_basic();
      test_random();
      test_timeout();
      test_ignored_start();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wavelet_row_sequencer.md
Name: wavelet_row_sequencer

Overview:
- Controller that sequences one `block_processor` pass over a LENGTH x LENGTH 8-bit image tile held in a row-wide frame memory.
- Fetches rows, loads the three row registers, pulses `en` with the correct `iter_flag`, then waits for the processor's result pulse before moving on.
- Sits between the frame memory and `block_processor`; a top-level start/done handshake replaces the bench-driven sequencing.

Parameters:
- ADDR_W, 8, frame-memory row address width.
- TIMEOUT, 1024, max cycles from the `en` pulse to `bp_result` rising before error abort.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to process a tile; ignored while busy=1.
- base_addr  in  ADDR_W  row address of tile row 0; sampled when start is accepted.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at end of pass, normal or aborted.
- err  out  1  sticky timeout flag; cleared on next accepted start.
- mem_rd  out  1  row read strobe.
- mem_addr  out  ADDR_W  row address.
- mem_rdata  in  8 x LENGTH  row data, valid exactly 1 cycle after mem_rd.
- bp_en  out  1  one-cycle enable to `block_processor`.
- bp_iter_flag  out  2  0=first, 1=middle, 2=last.
- bp_row_0, bp_row_1, bp_row_2  out  8 x LENGTH  row registers to `block_processor`.
- bp_result  in  1  processor completion level (rises, stays high >=1 cycle, falls).

Behaviour:
- Reset values: all outputs 0, row registers 0, state IDLE. Reset mid-pass aborts immediately with no done pulse.
- Iterations per pass: NIT = LENGTH/2. LENGTH must be even and >=4, enforced by an elaboration-time assertion.
- Row plan for iteration k:
  - k=0: rows 0,1,2 loaded into row_0,row_1,row_2; flag 0.
  - 0<k<NIT-1: rows 2k+1 and 2k+2 loaded into row_1,row_2; flag 1.
  - k=NIT-1: row LENGTH-1 loaded into row_1; flag 2.
  - row_0 is written only at k=0. Registers not reloaded hold their value.
- States:
  - IDLE: wait for start.
  - FETCH: one mem_rd per cycle, back-to-back, addr = base_addr + row.
  - LAST_CAP: capture the final row of the iteration.
  - FIRE: bp_en=1 for exactly 1 cycle.
  - WAIT_HI: wait for bp_result=1.
  - WAIT_LO: wait for bp_result=0.
  - then NEXT iteration, or DONE.
- Capture timing: each mem_rdata is captured the cycle after its read. Iteration 0 therefore takes reads in cycles c..c+2, captures in c+1..c+3, and FIRE in c+4.
- bp_iter_flag is set at iteration entry and held stable from FIRE through WAIT_LO.
- bp_result already high in FIRE is not counted. WAIT_HI begins the cycle after FIRE.
- Timeout counter runs from FIRE; reaching TIMEOUT in WAIT_HI sets err, pulses done, returns to IDLE.
- DONE: done=1 for one cycle, busy drops in the same cycle, back to IDLE. A start in the done cycle is ignored; the earliest accepted start is the next cycle.
- Address arithmetic is modulo 2^ADDR_W (wrap-around permitted, no error).

Decomposition:
- Package `essentials`: LENGTH (existing), `row_t` (8-bit x LENGTH array), `iter_flag_e` enum {FIRST=0, MIDDLE=1, LAST=2}, `seq_state_e` enum.
- No sub-module needed. The optional natural split is `row_fetch_unit`: read issue plus capture steering, returning a rows_ready strobe.

Test Plan (LENGTH=8, behavioural memory row r = {8{r+base}}):
- start, base_addr=0x10 -> reads at 0x10..0x17 in order; 4 bp_en pulses with flags 0,1,1,2; done after 4th result fall; err=0.
- Iteration 0 timing -> bp_en exactly 4 cycles after the first mem_rd; rows 0x10/0x11/0x12 present on row_0/1/2 in the FIRE cycle.
- Middle/last loads -> row_0 stays 0x10 all pass; last iteration row_1=0x17, row_2 keeps 0x16.
- bp_result never rises, TIMEOUT=16 -> err=1 and done pulse 16 cycles after bp_en; next start clears err.
- start pulsed during busy, and in the done cycle -> ignored, no extra reads.
- resetn low during WAIT_HI -> all outputs 0 asynchronously, no done pulse; a fresh start runs a full pass correctly.
